gray_to_binary_serial: RTL



---
 rtl/gray_to_binary_serial.sv | 103 ++++++++++
 1 files changed

// File: rtl/gray_to_binary_serial.sv
// Serial Gray-to-binary decoder: accepts one Gray word, resolves it MSB-first
// one bit per clock, then holds the binary result on a valid/ready output.
module gray_to_binary_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             busy
);

    localparam int            IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] I_TOP = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] g_reg, g_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] bin_reg, bin_next;
    logic [IW-1:0]    i_reg, i_next;
    logic [WIDTH-1:0] bit_val;

    // Candidate value for every bit position; only the one at i_reg is committed.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_msb
                assign bit_val[gi] = g_reg[gi];
            end else begin : g_low
                assign bit_val[gi] = g_reg[gi] ^ b_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        g_next     = g_reg;
        b_next     = b_reg;
        bin_next   = bin_reg;
        i_next     = i_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    g_next     = gray_in;
                    b_next     = '0;
                    i_next     = I_TOP;
                    state_next = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                for (int k = 0; k < WIDTH; k++) begin
                    if (i_reg == IW'(k)) begin
                        b_next[k] = bit_val[k];
                    end
                end
                // The last bit is folded into bin_out in the same cycle it is resolved.
                if (i_reg == '0) begin
                    bin_next   = b_next;
                    state_next = DONE;
                end else begin
                    i_next = i_reg - IW'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            g_reg     <= '0;
            b_reg     <= '0;
            bin_reg   <= '0;
            i_reg     <= '0;
        end else begin
            state_reg <= state_next;
            g_reg     <= g_next;
            b_reg     <= b_next;
            bin_reg   <= bin_next;
            i_reg     <= i_next;
        end
    end

    assign bin_out = bin_reg;

endmodule
